// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus responder: state encodings, default
// widths and the legal wait-state range.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;
   localparam int MAX_WAIT   = 15;

   // The wait-state counter is 4 bits wide, so anything above 15 cannot be loaded.
   function automatic bit wait_cycles_legal(input int w);
      return (w >= 0) && (w <= MAX_WAIT);
   endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Single-port synchronous RAM with write enable and a registered read port
// whose output register holds until the next enabled read.
module sync_ram_1rw #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array has no reset branch so it maps onto RAM macros; only the
   // read register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Device-side responder for the CPU memory handshake: samples FROM_D/TO_D,
// inserts WAIT_CYCLES wait states, accesses a local RAM and pulses ACK once.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              FROM_D,
   input  logic              TO_D,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ACK,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              proto_err
);

   if (!wait_cycles_legal(WAIT_CYCLES)) begin : g_wait_check
      $error("mem_bus_responder: WAIT_CYCLES must be within 0..15");
   end

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t            state;
   logic [3:0]        counter;
   logic              dir;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;
   logic              req;

   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;

   assign req = FROM_D | TO_D;

   // The RAM access happens on the edge that enters ACK. With zero wait states
   // that edge is the IDLE sampling edge, so the live bus values are used.
   always_comb begin
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = addr_l;
      ram_wdata = wdata_l;
      if (!reset) begin
         unique case (state)
            ST_IDLE: begin
               if (req && (WAIT_LD == 4'd0)) begin
                  ram_addr  = addr;
                  ram_wdata = wdata;
                  ram_we    = TO_D & ~FROM_D;
                  ram_re    = FROM_D;
               end
            end
            ST_WAIT: begin
               if (req && (counter == 4'd1)) begin
                  ram_we = dir;
                  ram_re = ~dir;
               end
            end
            default: ;
         endcase
      end
   end

   sync_ram_1rw #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (rdata)
   );

   // NOTE: all state and registered outputs update with <= so every branch
   // sees the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         counter   <= 4'd0;
         ACK       <= 1'b0;
         busy      <= 1'b0;
         proto_err <= 1'b0;
         dir       <= 1'b0;
         addr_l    <= '0;
         wdata_l   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               ACK <= 1'b0;
               if (req) begin
                  addr_l  <= addr;
                  wdata_l <= wdata;
                  // A conflicting request is demoted to a read so nothing is overwritten.
                  dir     <= TO_D & ~FROM_D;
                  counter <= WAIT_LD;
                  busy    <= 1'b1;
                  if (FROM_D && TO_D) proto_err <= 1'b1;
                  if (WAIT_LD != 4'd0) begin
                     state <= ST_WAIT;
                  end else begin
                     state <= ST_ACK;
                     ACK   <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state   <= ST_IDLE;
                  counter <= 4'd0;
                  busy    <= 1'b0;
               end else begin
                  if (counter != 4'd0) counter <= counter - 4'd1;
                  if (counter == 4'd1) begin
                     state <= ST_ACK;
                     ACK   <= 1'b1;
                  end
               end
            end
            ST_ACK: begin
               ACK   <= 1'b0;
               state <= ST_GAP;
            end
            ST_GAP: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with two wait states and
// one with zero wait states, checked with immediate assertions.
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        reset, from_d, to_d;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        ack, busy, proto_err;
   logic [15:0] rdata;

   logic        reset0, from_d0, to_d0;
   logic [7:0]  addr0;
   logic [15:0] wdata0;
   logic        ack0, busy0, proto_err0;
   logic [15:0] rdata0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_bus_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .FROM_D(from_d), .TO_D(to_d), .addr(addr),
      .wdata(wdata), .ACK(ack), .rdata(rdata), .busy(busy), .proto_err(proto_err)
   );

   mem_bus_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset0), .FROM_D(from_d0), .TO_D(to_d0), .addr(addr0),
      .wdata(wdata0), .ACK(ack0), .rdata(rdata0), .busy(busy0), .proto_err(proto_err0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a request until ACK (bounded), drop it, then wait through GAP to IDLE.
   task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [15:0] d, output int lat);
      from_d = rd;
      to_d   = wr;
      addr   = a;
      wdata  = d;
      lat    = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ack) begin
            lat = i;
            break;
         end
      end
      from_d = 1'b0;
      to_d   = 1'b0;
      tick();
      tick();
   endtask

   int lat;
   int acks;
   int first_ack, second_ack;

   initial begin
      reset = 1'b1; from_d = 1'b0; to_d = 1'b0; addr = '0; wdata = '0;
      reset0 = 1'b1; from_d0 = 1'b0; to_d0 = 1'b0; addr0 = '0; wdata0 = '0;
      tick();
      tick();
      reset  = 1'b0;
      reset0 = 1'b0;

      chk("reset_ack", ack, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_busy", busy, 0);
      chk("reset_proto_err", proto_err, 0);

      // Write 0xBEEF to 0x10, cycle by cycle.
      to_d = 1'b1; addr = 8'h10; wdata = 16'hBEEF;
      tick(); chk("wr_c1_ack", ack, 0); chk("wr_c1_busy", busy, 1);
      tick(); chk("wr_c2_ack", ack, 0); chk("wr_c2_busy", busy, 1);
      tick(); chk("wr_c3_ack", ack, 1); chk("wr_c3_busy", busy, 1);
      to_d = 1'b0;
      tick(); chk("wr_gap_ack", ack, 0); chk("wr_gap_busy", busy, 1);
      tick(); chk("wr_idle_busy", busy, 0);
      chk("wr_rdata_unchanged", rdata, 0);

      // Readback and hold.
      access(1'b1, 1'b0, 8'h10, 16'h0000, lat);
      chk("rd_latency", lat, 3);
      chk("rd_data", rdata, 16'hBEEF);
      for (int i = 0; i < 5; i++) tick();
      chk("rd_data_hold", rdata, 16'hBEEF);
      chk("rd_hold_ack", ack, 0);

      // Baselines for 0x20 and 0x30.
      access(1'b0, 1'b1, 8'h20, 16'h5555, lat);
      chk("wr20_latency", lat, 3);
      access(1'b0, 1'b1, 8'h30, 16'h7777, lat);
      chk("wr30_latency", lat, 3);

      // Abort a write after one wait cycle.
      to_d = 1'b1; addr = 8'h20; wdata = 16'h1234;
      tick();
      tick();
      to_d = 1'b0;
      tick(); chk("abort_ack", ack, 0); chk("abort_busy", busy, 0);
      tick(); chk("abort_ack_later", ack, 0);
      access(1'b1, 1'b0, 8'h20, 16'h0000, lat);
      chk("abort_rd_latency", lat, 3);
      chk("abort_rd_data", rdata, 16'h5555);

      // Held request: one ACK per access, spaced five cycles apart.
      from_d = 1'b1; addr = 8'h10;
      acks = 0; first_ack = 0; second_ack = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (ack) begin
            acks++;
            if (acks == 1) first_ack = i;
            if (acks == 2) second_ack = i;
         end
      end
      from_d = 1'b0;
      chk("held_ack_count", acks, 2);
      chk("held_first_ack", first_ack, 3);
      chk("held_spacing", second_ack - first_ack, 5);
      tick(); chk("held_abort_ack", ack, 0);
      tick(); chk("held_idle_busy", busy, 0);

      // Protocol error: both strobes high, treated as a read.
      access(1'b1, 1'b1, 8'h10, 16'h0000, lat);
      chk("perr_latency", lat, 3);
      chk("perr_flag", proto_err, 1);
      chk("perr_rdata", rdata, 16'hBEEF);
      access(1'b1, 1'b0, 8'h10, 16'h0000, lat);
      chk("perr_ram_intact", rdata, 16'hBEEF);
      chk("perr_sticky", proto_err, 1);

      // Reset while in WAIT; the commit edge sees reset.
      to_d = 1'b1; addr = 8'h30; wdata = 16'hAAAA;
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("rst_wait_ack", ack, 0);
      chk("rst_wait_busy", busy, 0);
      chk("rst_wait_proto_err", proto_err, 0);
      chk("rst_wait_rdata", rdata, 0);
      reset = 1'b0; to_d = 1'b0;
      tick(); chk("rst_wait_no_ack", ack, 0);
      access(1'b1, 1'b0, 8'h30, 16'h0000, lat);
      chk("rst_ram30_latency", lat, 3);
      chk("rst_ram30_data", rdata, 16'h7777);

      // Zero wait states: ACK the cycle after sampling.
      to_d0 = 1'b1; addr0 = 8'h05; wdata0 = 16'h4242;
      tick(); chk("w0_wr_ack", ack0, 1); chk("w0_wr_busy", busy0, 1);
      to_d0 = 1'b0;
      tick(); chk("w0_gap_ack", ack0, 0); chk("w0_gap_busy", busy0, 1);
      tick(); chk("w0_idle_busy", busy0, 0);
      chk("w0_rdata_after_wr", rdata0, 0);
      from_d0 = 1'b1;
      tick(); chk("w0_rd_ack", ack0, 1); chk("w0_rd_data", rdata0, 16'h4242);
      from_d0 = 1'b0;
      tick(); chk("w0_rd_gap_ack", ack0, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Device-side responder for the CPU controller's memory handshake. The controller raises FROM_D (read into CPU) or TO_D (write from CPU) during IF/FF/TF/EX/IT bus cycles and waits for ACK before it advances state.
- This block decodes the request, inserts a programmable number of wait states with a 4-bit down-counter, performs the access on a local synchronous RAM, and returns a one-cycle ACK pulse.

Parameters:
- ADDR_W, 8, address width; RAM depth is 2^ADDR_W words.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 2, wait states inserted before ACK; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- FROM_D  in  1  read request, level, held until ACK is seen.
- TO_D  in  1  write request, level, held until ACK is seen.
- addr  in  ADDR_W  word address, valid while a request is high.
- wdata  in  DATA_W  write data, valid while TO_D is high.
- ACK  out  1  one-cycle completion pulse, registered.
- rdata  out  DATA_W  read data, valid in the ACK cycle of a read.
- busy  out  1  high in WAIT, ACK and GAP states.
- proto_err  out  1  sticky flag: FROM_D and TO_D were both high when sampled.

Behaviour:
- Reset, on the edge where reset=1:
  - state=IDLE, counter=0, ACK=0, rdata=0, busy=0, proto_err=0.
  - RAM contents are not reset.
  - Reset overrides every other transition, including mid-WAIT and the ACK cycle. No write commits if reset is high at the commit edge.
- States are IDLE, WAIT, ACK and GAP, encoded as 2-bit constants.
- IDLE:
  - On an edge where FROM_D|TO_D=1, latch addr, wdata and direction (dir=TO_D), then load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise ACK.
- WAIT:
  - counter decrements by 1 each clock. When counter==1 at an edge, the next state is ACK.
  - Abort: if FROM_D=0 and TO_D=0 at any WAIT edge, go to IDLE, clear counter, issue no ACK, perform no write.
  - Changes to direction, address or data during WAIT are ignored; the latched values are used.
- Entering ACK:
  - Write (dir=1): RAM[addr_l] <= wdata_l on that edge.
  - Read: rdata <= RAM[addr_l] on that edge.
  - ACK=1 for exactly one cycle.
- Latency: ACK is high in cycle k+1+WAIT_CYCLES, where k is the IDLE sampling edge. WAIT_CYCLES=0 gives ACK in the cycle after the request is sampled.
- ACK -> GAP (always one cycle, ACK=0) -> IDLE.
  - The mandatory GAP ensures a request level still high from the CPU's previous state is never treated as a second access.
  - Back-to-back accesses are therefore spaced WAIT_CYCLES+3 cycles apart.
- rdata holds its value until the next read ACK. Writes never change rdata.
- FROM_D and TO_D both high when sampled in IDLE:
  - proto_err <= 1 (sticky until reset).
  - The request is treated as a read: no RAM write, normal wait states and ACK, so the CPU never hangs.
- Counter width is 4 bits, with no wrap: decrement occurs only in WAIT while counter>0.
- Requests arriving in ACK or GAP are not sampled until IDLE.

Decomposition:
- Shared package mem_bus_pkg:
  - State encodings ST_IDLE, ST_WAIT, ST_ACK, ST_GAP.
  - Default ADDR_W and DATA_W.
  - Compile-time check that WAIT_CYCLES <= 15.
- One sub-module, sync_ram_1rw: single-port synchronous RAM with a write enable and a registered read port.
- The wait-state counter stays inline, a down-counter paired with the controller's up-counter style.

Test Plan:
- Reset, then write: WAIT_CYCLES=2, TO_D=1, addr=0x10, wdata=0xBEEF held. ACK is high 3 cycles after the sampling edge for exactly 1 cycle, then GAP, then IDLE; busy is high for 4 cycles.
- Readback: FROM_D=1, addr=0x10. ACK with rdata=0xBEEF; rdata is still 0xBEEF 5 cycles later.
- Abort: TO_D=1, addr=0x20, wdata=0x1234, dropped after 1 wait cycle. No ACK, state returns to IDLE; a later read of 0x20 does not return 0x1234.
- Held request / back-to-back: FROM_D stays high across two CPU states. Exactly one ACK per access, and ACK pulses are spaced WAIT_CYCLES+3=5 cycles apart.
- Protocol error: FROM_D=TO_D=1, addr=0x10, wdata=0x0000. proto_err=1 and sticky, ACK is issued, RAM[0x10] is still 0xBEEF.
- Reset mid-WAIT during a write to 0x30 with wdata=0xAAAA. All outputs return to 0, no ACK, and RAM[0x30] is unchanged. Repeat with WAIT_CYCLES=0: ACK is high 1 cycle after sampling.
